// File: rtl/vip_stream_decoder.sv
// Avalon-ST sink for the VIP pipeline: decodes control packets into frame
// geometry and feeds video pixels to the core through a 2-entry buffer.
module vip_stream_decoder #(
    parameter int BITS_PER_SYMBOL  = 8,
    parameter int SYMBOLS_PER_BEAT = 3
) (
    input  logic                                        clk,
    input  logic                                        rst,
    input  logic [BITS_PER_SYMBOL*SYMBOLS_PER_BEAT-1:0] din_data,
    input  logic                                        din_valid,
    input  logic                                        din_sop,
    input  logic                                        din_eop,
    output logic                                        din_ready,
    input  logic                                        read,
    output logic                                        stall_in,
    output logic [BITS_PER_SYMBOL*SYMBOLS_PER_BEAT-1:0] data_in,
    output logic                                        end_of_video,
    output logic [15:0]                                 width_in,
    output logic [15:0]                                 height_in,
    output logic [3:0]                                  interlaced_in,
    output logic                                        vip_ctrl_valid
);
    localparam int DW = BITS_PER_SYMBOL * SYMBOLS_PER_BEAT;

    typedef enum logic [1:0] {ST_IDLE, ST_CTRL, ST_VIDEO, ST_DISCARD} state_t;

    state_t      state_reg, state_next;
    logic        din_ready_reg;
    logic        accept, push, pop, ctrl_beat;
    logic [DW:0] buf_mem [0:1];
    logic        rd_ptr_reg, wr_ptr_reg;
    logic [1:0]  count_reg, count_next;
    logic [DW:0] head;
    logic [1:0]  ctrl_cnt_reg;
    logic [15:0] shadow_w_reg;
    logic [7:0]  shadow_h_hi_reg;
    logic [15:0] width_reg, height_reg;
    logic [3:0]  interlaced_reg;
    logic        ctrl_valid_reg;
    logic [3:0]  sym_nib [SYMBOLS_PER_BEAT];

    // Low nibble of every symbol carries the control-packet payload.
    for (genvar gi = 0; gi < SYMBOLS_PER_BEAT; gi++) begin : g_nib
        assign sym_nib[gi] = din_data[gi*BITS_PER_SYMBOL +: 4];
    end

    assign accept    = din_valid & din_ready_reg;
    assign push      = accept & ~din_sop & (state_reg == ST_VIDEO);
    assign pop       = read & (count_reg != 2'd0);
    assign ctrl_beat = accept & ~din_sop & (state_reg == ST_CTRL);

    always_comb begin
        state_next = state_reg;
        if (accept) begin
            if (din_sop) begin
                if (din_eop)
                    state_next = ST_IDLE;
                else if (din_data[3:0] == 4'hF)
                    state_next = ST_CTRL;
                else if (din_data[3:0] == 4'h0)
                    state_next = ST_VIDEO;
                else
                    state_next = ST_DISCARD;
            end else if (din_eop) begin
                state_next = ST_IDLE;
            end
        end
    end

    always_comb begin
        count_next = count_reg;
        if (push && !pop)
            count_next = count_reg + 2'd1;
        else if (!push && pop)
            count_next = count_reg - 2'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= ST_IDLE;
            din_ready_reg <= 1'b0;
            count_reg     <= 2'd0;
            rd_ptr_reg    <= 1'b0;
            wr_ptr_reg    <= 1'b0;
            for (int i = 0; i < 2; i++)
                buf_mem[i] <= '0;
        end else begin
            state_reg <= state_next;
            count_reg <= count_next;
            if (push) begin
                buf_mem[wr_ptr_reg] <= {din_eop, din_data};
                wr_ptr_reg          <= ~wr_ptr_reg;
            end
            if (pop)
                rd_ptr_reg <= ~rd_ptr_reg;
            // Outside VIDEO, hold off upstream until queued pixels have drained.
            if (state_next == ST_VIDEO)
                din_ready_reg <= (count_next < 2'd2);
            else
                din_ready_reg <= (count_next == 2'd0);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ctrl_cnt_reg    <= 2'd0;
            shadow_w_reg    <= 16'd0;
            shadow_h_hi_reg <= 8'd0;
            width_reg       <= 16'd640;
            height_reg      <= 16'd480;
            interlaced_reg  <= 4'd0;
            ctrl_valid_reg  <= 1'b0;
        end else begin
            ctrl_valid_reg <= 1'b0;
            if (accept && din_sop) begin
                ctrl_cnt_reg <= 2'd0;
            end else if (ctrl_beat) begin
                case (ctrl_cnt_reg)
                    2'd0: begin
                        shadow_w_reg[15:4] <= {sym_nib[0], sym_nib[1], sym_nib[2]};
                        ctrl_cnt_reg       <= 2'd1;
                    end
                    2'd1: begin
                        shadow_w_reg[3:0] <= sym_nib[0];
                        shadow_h_hi_reg   <= {sym_nib[1], sym_nib[2]};
                        ctrl_cnt_reg      <= 2'd2;
                    end
                    2'd2: begin
                        width_reg      <= shadow_w_reg;
                        height_reg     <= {shadow_h_hi_reg, sym_nib[0], sym_nib[1]};
                        interlaced_reg <= sym_nib[2];
                        ctrl_valid_reg <= 1'b1;
                        ctrl_cnt_reg   <= 2'd3;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign head           = buf_mem[rd_ptr_reg];
    assign din_ready      = din_ready_reg;
    assign stall_in       = (count_reg == 2'd0);
    assign data_in        = stall_in ? '0 : head[DW-1:0];
    assign end_of_video   = ~stall_in & head[DW];
    assign width_in       = width_reg;
    assign height_in      = height_reg;
    assign interlaced_in  = interlaced_reg;
    assign vip_ctrl_valid = ctrl_valid_reg;

    a_no_overflow: assert property (@(posedge clk) disable iff (rst) !(push && count_reg == 2'd2));

endmodule

// File: tb/tb_vip_stream_decoder.sv
// Bench for vip_stream_decoder: packet-level reference model with a per-cycle
// compare, directed scenarios with literal expectations, then random packets.
module tb_vip_stream_decoder;
    logic        clk = 1'b0;
    logic        rst;
    logic [23:0] din_data = '0;
    logic        din_valid = 1'b0, din_sop = 1'b0, din_eop = 1'b0;
    logic        din_ready;
    logic        read = 1'b0;
    logic        stall_in;
    logic [23:0] data_in;
    logic        end_of_video;
    logic [15:0] width_in, height_in;
    logic [3:0]  interlaced_in;
    logic        vip_ctrl_valid;

    vip_stream_decoder #(.BITS_PER_SYMBOL(8), .SYMBOLS_PER_BEAT(3)) dut (
        .clk(clk), .rst(rst),
        .din_data(din_data), .din_valid(din_valid), .din_sop(din_sop), .din_eop(din_eop),
        .din_ready(din_ready), .read(read), .stall_in(stall_in), .data_in(data_in),
        .end_of_video(end_of_video), .width_in(width_in), .height_in(height_in),
        .interlaced_in(interlaced_in), .vip_ctrl_valid(vip_ctrl_valid)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: packet context, pixel queue, nibble list for control packets.
    int          m_mode = 0;   // 0 none, 1 control, 2 video, 3 other
    logic        m_ready = 1'b0;
    logic        m_pulse = 1'b0;
    logic [15:0] m_w = 16'd640, m_h = 16'd480;
    logic [3:0]  m_il = 4'd0;
    logic [24:0] m_q[$];
    logic [3:0]  m_nib[$];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_mode = 0; m_ready = 1'b0; m_pulse = 1'b0;
            m_w = 16'd640; m_h = 16'd480; m_il = 4'd0;
            m_q.delete(); m_nib.delete();
        end else begin
            bit acc;
            acc = din_valid && m_ready;
            m_pulse = 1'b0;
            if (read && m_q.size() > 0) void'(m_q.pop_front());
            if (acc) begin
                if (din_sop) begin
                    m_nib.delete();
                    if (din_eop) m_mode = 0;
                    else if (din_data[3:0] == 4'hF) m_mode = 1;
                    else if (din_data[3:0] == 4'h0) m_mode = 2;
                    else m_mode = 3;
                end else begin
                    if (m_mode == 1 && m_nib.size() < 9) begin
                        for (int k = 0; k < 3; k++) m_nib.push_back(din_data[8*k +: 4]);
                        if (m_nib.size() == 9) begin
                            m_w = {m_nib[0], m_nib[1], m_nib[2], m_nib[3]};
                            m_h = {m_nib[4], m_nib[5], m_nib[6], m_nib[7]};
                            m_il = m_nib[8];
                            m_pulse = 1'b1;
                        end
                    end else if (m_mode == 2) begin
                        m_q.push_back({din_eop, din_data});
                    end
                    if (din_eop) m_mode = 0;
                end
            end
            m_ready = (m_mode == 2) ? (m_q.size() < 2) : (m_q.size() == 0);
        end
    end

    int          pulse_cnt = 0;
    logic [24:0] pops[$];

    always @(negedge clk) begin
        if (rst) begin
            chk("rst_din_ready", din_ready, 0);
            chk("rst_stall_in", stall_in, 1);
            chk("rst_data_in", data_in, 0);
            chk("rst_end_of_video", end_of_video, 0);
            chk("rst_width", width_in, 640);
            chk("rst_height", height_in, 480);
            chk("rst_interlaced", interlaced_in, 0);
            chk("rst_ctrl_valid", vip_ctrl_valid, 0);
        end else begin
            chk("din_ready", din_ready, m_ready);
            chk("stall_in", stall_in, m_q.size() == 0);
            chk("vip_ctrl_valid", vip_ctrl_valid, m_pulse);
            chk("width_in", width_in, m_w);
            chk("height_in", height_in, m_h);
            chk("interlaced_in", interlaced_in, m_il);
            if (m_q.size() > 0) begin
                chk("data_in", data_in, m_q[0][23:0]);
                chk("end_of_video", end_of_video, m_q[0][24]);
            end
            if (vip_ctrl_valid) pulse_cnt++;
            if (read && !stall_in) pops.push_back({end_of_video, data_in});
        end
    end

    bit   rand_read = 1'b0;
    logic read_force = 1'b0;
    int   gap_max = 0;

    always @(posedge clk) begin
        #1;
        read = rand_read ? 1'($urandom_range(0, 1)) : read_force;
    end

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic place(input logic [23:0] d, input logic s, input logic e);
        din_data = d; din_sop = s; din_eop = e; din_valid = 1'b1;
    endtask

    task automatic beat(input logic [23:0] d, input logic s, input logic e);
        int n = 0;
        bit acc = 1'b0;
        if (gap_max > 0) begin
            din_valid = 1'b0;
            idle($urandom_range(0, gap_max));
        end
        place(d, s, e);
        while (!acc && n < 300) begin
            @(negedge clk);
            acc = din_ready;
            @(posedge clk); #1;
            n++;
        end
        chk("beat_accepted", acc, 1);
        din_valid = 1'b0; din_sop = 1'b0; din_eop = 1'b0;
    endtask

    task automatic wait_empty();
        int n = 0;
        while (!stall_in && n < 300) begin @(posedge clk); #1; n++; end
        chk("drain_done", stall_in, 1);
    endtask

    initial begin
        int p0;
        rst = 1'b1;
        idle(3);
        rst = 1'b0;
        #1 chk("ready_low_after_release", din_ready, 0);
        idle(1);
        chk("ready_high_one_cycle_later", din_ready, 1);
        chk("stall_after_reset", stall_in, 1);

        // Truncated control packet: eop on beat 2
        beat(24'h00000F, 1, 0); beat(24'h080700, 0, 0); beat(24'h040000, 0, 1);
        idle(3);
        chk("trunc_width", width_in, 640);
        chk("trunc_height", height_in, 480);
        chk("trunc_interlaced", interlaced_in, 0);
        chk("trunc_no_pulse", pulse_cnt, 0);

        // Full 1920x1080 control packet
        beat(24'h00000F, 1, 0); beat(24'h080700, 0, 0); beat(24'h040000, 0, 0); beat(24'h000803, 0, 1);
        idle(3);
        chk("ctrl_width", width_in, 1920);
        chk("ctrl_height", height_in, 1080);
        chk("ctrl_interlaced", interlaced_in, 0);
        chk("ctrl_one_pulse", pulse_cnt, 1);

        // Video with backpressure
        read_force = 1'b0; idle(2);
        beat(24'h000000, 1, 0); beat(24'h111111, 0, 0); beat(24'h222222, 0, 0);
        place(24'h333333, 0, 1);
        idle(3);
        chk("bp_ready_low", din_ready, 0);
        chk("bp_stall", stall_in, 0);
        chk("bp_head", data_in, 24'h111111);
        pops.delete();
        read_force = 1'b1;
        beat(24'h333333, 0, 1);
        wait_empty(); idle(2);
        chk("bp_pop_count", pops.size(), 3);
        if (pops.size() == 3) begin
            chk("bp_pop0", pops[0], {1'b0, 24'h111111});
            chk("bp_pop1", pops[1], {1'b0, 24'h222222});
            chk("bp_pop2", pops[2], {1'b1, 24'h333333});
        end
        beat(24'h999999, 0, 0);   // stray beat outside a packet is dropped
        idle(3);
        chk("stray_not_forwarded", stall_in, 1);

        // Discard packet of another type
        p0 = pulse_cnt;
        beat(24'h000005, 1, 0); beat(24'h00000F, 0, 0); beat(24'h123456, 0, 0);
        beat(24'h000000, 0, 0); beat(24'hABCDEF, 0, 1);
        idle(3);
        chk("discard_no_pixels", stall_in, 1);
        chk("discard_no_pulse", pulse_cnt, p0);

        // Control header waits behind queued pixels
        read_force = 1'b0; idle(2);
        beat(24'h000000, 1, 0); beat(24'hAAAAAA, 0, 0); beat(24'hBBBBBB, 0, 1);
        place(24'h00000F, 1, 0);
        idle(4);
        chk("order_ready_held", din_ready, 0);
        chk("order_stall", stall_in, 0);
        pops.delete();
        read_force = 1'b1;
        beat(24'h00000F, 1, 0);
        chk("order_drained_first", pops.size(), 2);
        beat(24'h000500, 0, 0); beat(24'h020000, 0, 0); beat(24'h01000D, 0, 1);
        idle(3);
        chk("ctrl2_width", width_in, 1280);
        chk("ctrl2_height", height_in, 720);
        chk("ctrl2_interlaced", interlaced_in, 1);

        // Aborted frame
        read_force = 1'b0; idle(2);
        pops.delete();
        beat(24'h000000, 1, 0); beat(24'hC1C1C1, 0, 0); beat(24'hC2C2C2, 0, 0);
        place(24'h000000, 1, 0);
        idle(3);
        chk("abort_ready_low", din_ready, 0);
        read_force = 1'b1;
        beat(24'h000000, 1, 0); beat(24'hD1D1D1, 0, 0); beat(24'hD2D2D2, 0, 1);
        wait_empty(); idle(2);
        chk("abort_pop_count", pops.size(), 4);
        if (pops.size() == 4) begin
            chk("abort_pop0", pops[0], {1'b0, 24'hC1C1C1});
            chk("abort_pop1", pops[1], {1'b0, 24'hC2C2C2});
            chk("abort_pop2", pops[2], {1'b0, 24'hD1D1D1});
            chk("abort_pop3", pops[3], {1'b1, 24'hD2D2D2});
        end

        // Random packets against the model
        rand_read = 1'b1; gap_max = 2;
        for (int p = 0; p < 60; p++) begin
            int t, len;
            logic [3:0] ty;
            t = $urandom_range(0, 2);
            ty = (t == 0) ? 4'hF : (t == 1) ? 4'h0 : 4'h5;
            len = $urandom_range(0, 5);
            beat({$urandom_range(0, 24'hFFFFF), ty}, 1, len == 0);
            for (int b = 0; b < len; b++)
                beat(24'($urandom), 0, b == len - 1);
        end
        rand_read = 1'b0; read_force = 1'b0; gap_max = 0;
        idle(4);

        // Reset in the middle of a video frame
        beat(24'h000000, 1, 0); beat(24'h123456, 0, 0); beat(24'h654321, 0, 0);
        #1 rst = 1'b1;
        #1;
        chk("midrst_ready", din_ready, 0);
        chk("midrst_stall", stall_in, 1);
        chk("midrst_data", data_in, 0);
        chk("midrst_eov", end_of_video, 0);
        chk("midrst_width", width_in, 640);
        chk("midrst_height", height_in, 480);
        chk("midrst_interlaced", interlaced_in, 0);
        chk("midrst_ctrl_valid", vip_ctrl_valid, 0);
        idle(2);
        rst = 1'b0;
        #1 chk("midrst_ready_release", din_ready, 0);
        idle(1);
        chk("midrst_ready_up", din_ready, 1);
        beat(24'h777777, 0, 0);
        idle(3);
        chk("midrst_needs_sop", stall_in, 1);
        read_force = 1'b1;
        beat(24'h000000, 1, 0); beat(24'hABCDEF, 0, 1);
        wait_empty(); idle(3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/vip_stream_decoder.md
Name: vip_stream_decoder

Overview:
- Sink side of the VIP pipeline: accepts an Avalon-ST video stream (sop/eop packets, 3 symbols per beat), parses control packets into width/height/interlaced fields and forwards video-packet pixels to the algorithm core.
- Drives the core's input flow-control interface: stall_in, data_in, end_of_video, width_in, height_in, interlaced_in, vip_ctrl_valid.
- A 2-entry pixel buffer with a registered din_ready breaks the combinational ready path between the core and the upstream source.

Parameters:
BITS_PER_SYMBOL, 8, bits per colour symbol
SYMBOLS_PER_BEAT, 3, symbols per beat; control-packet parsing is defined for 3 only

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
din_data  in  24  Avalon-ST data; symbol0 in [7:0]
din_valid  in  1  beat valid
din_sop  in  1  start of packet
din_eop  in  1  end of packet
din_ready  out  1  registered ready to upstream
read  in  1  core ready to take a pixel
stall_in  out  1  1 = no pixel available for the core
data_in  out  24  pixel to the core (buffer head)
end_of_video  out  1  head pixel is the last of its frame
width_in  out  16  last decoded width
height_in  out  16  last decoded height
interlaced_in  out  4  last decoded interlace nibble
vip_ctrl_valid  out  1  1-cycle pulse when a complete control packet has been decoded

Behaviour:
- Beat accepted when din_valid & din_ready.
- Packet type is din_data[3:0] of an sop beat: 0xF = control, 0x0 = video, anything else = other.
- States:
  - IDLE: wait for an sop beat.
  - CTRL: collect control beats.
  - VIDEO: forward pixels.
  - DISCARD: drop beats until eop.
- Transitions:
  - An accepted sop beat, in any state, is consumed as a header and is never forwarded.
  - Header type 0xF -> CTRL; 0x0 -> VIDEO; other -> DISCARD.
  - If the header beat also has eop: go to IDLE, nothing emitted.
  - Accepted eop in CTRL, VIDEO or DISCARD -> IDLE.
- Control packet decoding: nibbles are bits [3:0] of each symbol, symbol0 first.
  - Beat 1 = w[15:12], w[11:8], w[7:4].
  - Beat 2 = w[3:0], h[15:12], h[11:8].
  - Beat 3 = h[7:4], h[3:0], interlaced.
- Control field update:
  - Nibbles assemble in shadow registers.
  - width_in/height_in/interlaced_in update together in the cycle after beat 3 is accepted; vip_ctrl_valid pulses high for exactly that cycle.
  - Beats after beat 3 are ignored.
  - If eop arrives before beat 3: no pulse, outputs unchanged.
- VIDEO state:
  - Each accepted non-sop beat is pushed as {din_eop, din_data}.
  - end_of_video = stored eop of the head entry.
- Core interface:
  - stall_in = (count == 0).
  - data_in/end_of_video = head entry.
  - Pop when read & ~stall_in.
  - Push and pop in the same cycle are allowed; count is unchanged.
  - Latency: a pixel accepted at cycle N is visible with stall_in=0 at N+1.
- din_ready, registered from next-state values:
  - Next state VIDEO: 1 iff count_next < 2.
  - Otherwise: 1 iff count_next == 0, so a control packet never overtakes queued pixels.
  - Overflow is impossible; pushing while count == 2 is a design error, caught by an assertion.
- Aborted frame (sop mid-VIDEO): already-buffered pixels still drain; no end_of_video is generated for the aborted frame.
- Reset values:
  - din_ready=0, stall_in=1, data_in=0, end_of_video=0.
  - width_in=640, height_in=480, interlaced_in=0, vip_ctrl_valid=0.
  - State IDLE, count 0, shadow registers cleared.
  - din_ready rises 1 cycle after rst deasserts.
- Reset mid-packet: buffer flushed; partial control fields discarded; the next packet is recognised only by a new sop.

Test Plan:
- Reset: assert rst mid-frame -> all outputs take reset values immediately; din_ready=1 one cycle after release; stall_in=1.
- Control packet: sop beat 0x00000F, then 0x080700, 0x040000, 0x000803 (eop) -> one vip_ctrl_valid pulse; width_in=1920, height_in=1080, interlaced_in=0.
- Truncated control packet: header plus 2 beats with eop on beat 2 -> no pulse; outputs stay 640/480/0.
- Video with backpressure: header 0x000000, then pixels 0x111111, 0x222222, 0x333333 (eop) with read=0 -> din_ready drops after 2 pixels queued. Then read=1 -> pixels delivered in order; end_of_video=1 only with 0x333333; state returns to IDLE.
- Discard and ordering: sop type 0x5 with 4 beats -> no pixels emitted, no pulse. Then a control header arriving while 2 pixels are queued -> din_ready held 0 until the buffer is empty.
- Abort: new video sop after 2 pixels of a frame -> both pixels drain with end_of_video=0; the new frame's pixels follow.
